// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is cut
//   into GROUP_W-bit lookahead groups; each pipeline stage resolves one group
//   and registers its carry-out for the next stage. Valid/ready flow control
//   with a full-pipeline stall on output backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   a, b       operands (WIDTH bits)
//   sub        1 = A - B, 0 = A + B
//   cin        carry-in (add) / borrow-in (sub)
//   out_valid  result beat valid
//   out_ready  consumer accepts the result this cycle
//   sum        result (WIDTH bits)
//   cout       raw carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        two's-complement signed overflow
module cla_pipe_addsub #(
    parameter int WIDTH   = 16,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / GROUP_W;

    // Flattened lookahead: every carry is a sum of products of g/p terms and
    // the group carry-in, so no carry ripples through the group.
    // Result bit 0 is the carry-in, bit i is the carry into bit i, bit GROUP_W
    // is the group carry-out.
    function automatic logic [GROUP_W:0] cla_carries(
        input logic [GROUP_W-1:0] ga,
        input logic [GROUP_W-1:0] gb,
        input logic               ci
    );
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
        logic [GROUP_W:0]   c;
        logic               term;
        p    = ga ^ gb;
        g    = ga & gb;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP_W; i++) begin
            c[i+1] = g[i];
            term   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (term & g[j]);
                term   = term & p[j];
            end
            c[i+1] = c[i+1] | (term & ci);
        end
        return c;
    endfunction

    // Per-stage pipeline registers. acc holds the not-yet-consumed A groups in
    // its low part and the finished sum groups in its high part: each stage
    // shifts right by one group and drops its sum group in at the top, so after
    // the last stage acc is exactly the in-order result (skew + deskew in one).
    logic [STAGES-1:0]              vld_q, vld_d;
    logic [STAGES-1:0]              cy_q, cy_d;
    logic [STAGES-1:0][WIDTH-1:0]   acc_q, acc_d;
    logic [STAGES-1:0][WIDTH-1:0]   bsk_q, bsk_d;
    logic                           ovf_q, ovf_d;

    // Stage inputs and combinational group results
    logic [STAGES-1:0][WIDTH-1:0]   st_a;
    logic [STAGES-1:0][WIDTH-1:0]   st_b;
    logic [STAGES-1:0]              st_c;
    logic [STAGES-1:0]              st_v;
    logic [STAGES-1:0][GROUP_W:0]   st_cv;
    logic [STAGES-1:0][GROUP_W-1:0] st_s;

    logic stall;

    // Operand conditioning: subtract is A + ~B + 1, borrow-in drops the +1.
    assign st_a[0] = a;
    assign st_b[0] = b ^ {WIDTH{sub}};
    assign st_c[0] = cin ^ sub;
    assign st_v[0] = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign st_a[k] = acc_q[k-1];
        assign st_b[k] = bsk_q[k-1];
        assign st_c[k] = cy_q[k-1];
        assign st_v[k] = vld_q[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign st_cv[k] = cla_carries(st_a[k][GROUP_W-1:0], st_b[k][GROUP_W-1:0], st_c[k]);
        assign st_s[k]  = st_a[k][GROUP_W-1:0] ^ st_b[k][GROUP_W-1:0] ^ st_cv[k][GROUP_W-1:0];
    end

    assign out_valid = vld_q[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // The whole pipe freezes on stall; bubbles advance like real beats.
    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        acc_d = acc_q;
        bsk_d = bsk_q;
        ovf_d = ovf_q;
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k] = st_v[k];
                cy_d[k]  = st_cv[k][GROUP_W];
                acc_d[k] = (st_a[k] >> GROUP_W) | (WIDTH'(st_s[k]) << (WIDTH - GROUP_W));
                bsk_d[k] = st_b[k] >> GROUP_W;
            end
            // carry into the MSB vs carry out of the MSB, both in the last group
            ovf_d = st_cv[STAGES-1][GROUP_W] ^ st_cv[STAGES-1][GROUP_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            acc_q <= '0;
            bsk_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            acc_q <= acc_d;
            bsk_q <= bsk_d;
            ovf_q <= ovf_d;
        end
    end

    // The last stage's B skew has no consumer; synthesis trims it.
    logic unused_skew;
    assign unused_skew = ^bsk_q[STAGES-1];

    assign sum  = acc_q[STAGES-1];
    assign cout = cy_q[STAGES-1];
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub
//   Self-checking bench: a 16-bit / 4-bit-group instance for directed and
//   random traffic, and an 8-bit single-stage instance for random traffic.
//   Expected results are pushed to a queue on every accepted beat and popped
//   when the DUT hands a result over.
`timescale 1ns/1ps
module tb_cla_pipe_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    cla_pipe_addsub #(.WIDTH(16), .GROUP_W(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16), .cin(cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    cla_pipe_addsub #(.WIDTH(8), .GROUP_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    res_t q16[$];
    res_t q8[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Golden model: w-bit A + (B or ~B) + (cin ^ sub); overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input logic c);
        logic [16:0] mask;
        logic [16:0] t;
        logic [15:0] yp;
        res_t        r;
        mask = (17'd1 << w) - 17'd1;
        yp   = (s ? ~y : y) & mask[15:0];
        t    = ({1'b0, x} & mask) + {1'b0, yp} + {16'd0, c ^ s};
        r.s  = t[15:0] & mask[15:0];
        r.co = t[w];
        r.ov = (x[w-1] == yp[w-1]) && (r.s[w-1] != x[w-1]);
        return r;
    endfunction

    // Per-cycle bookkeeping, called at a negedge after inputs are driven;
    // returns at the next negedge.
    logic hold16 = 1'b0, acc16 = 1'b0, hold8 = 1'b0, acc8 = 1'b0;
    res_t last16, last8;
    int   stalls16 = 0, n_pop16 = 0, n_pop8 = 0;

    task automatic tick16();
        res_t o, e;
        #1;
        o = {sum16, cout16, ovf16};
        check_eq("dut16 in_ready", 32'(in_ready16), 32'(!(out_valid16 && !out_ready16)));
        if (hold16) begin
            check_eq("dut16 held out_valid", 32'(out_valid16), 32'd1);
            check_eq("dut16 held result", 32'(o), 32'(last16));
        end
        hold16 = out_valid16 && !out_ready16;
        last16 = o;
        if (hold16) stalls16++;
        if (out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                check_eq("dut16 unexpected result", 32'(out_valid16), 32'd0);
            end else begin
                e = q16.pop_front();
                check_eq("dut16 result", 32'(o), 32'(e));
                n_pop16++;
            end
        end
        acc16 = in_valid16 && in_ready16;
        if (acc16) q16.push_back(model(16, a16, b16, sub16, cin16));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick8();
        res_t o, e;
        #1;
        o = {8'd0, sum8, cout8, ovf8};
        check_eq("dut8 in_ready", 32'(in_ready8), 32'(!(out_valid8 && !out_ready8)));
        if (hold8) begin
            check_eq("dut8 held out_valid", 32'(out_valid8), 32'd1);
            check_eq("dut8 held result", 32'(o), 32'(last8));
        end
        hold8 = out_valid8 && !out_ready8;
        last8 = o;
        if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                check_eq("dut8 unexpected result", 32'(out_valid8), 32'd0);
            end else begin
                e = q8.pop_front();
                check_eq("dut8 result", 32'(o), 32'(e));
                n_pop8++;
            end
        end
        acc8 = in_valid8 && in_ready8;
        if (acc8) q8.push_back(model(8, {8'd0, a8}, {8'd0, b8}, sub8, cin8));
        @(posedge clk);
        @(negedge clk);
    endtask

    // One beat with an empty pipe: checks latency and the literal expected result.
    task automatic send16(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic c,
                          input logic [15:0] es, input logic eco, input logic eov);
        int lat;
        a16 = x; b16 = y; sub16 = s; cin16 = c;
        in_valid16 = 1'b1; out_ready16 = 1'b1;
        tick16();
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 20) begin
            tick16();
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'd4);
        check_eq({tag, " sum"}, 32'(sum16), 32'(es));
        check_eq({tag, " cout"}, 32'(cout16), 32'(eco));
        check_eq({tag, " ovf"}, 32'(ovf16), 32'(eov));
        tick16();
    endtask

    initial begin
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; sub16 = 1'b0; cin16 = 1'b0;
        in_valid8  = 1'b0; out_ready8  = 1'b1; a8  = '0; b8  = '0; sub8  = 1'b0; cin8  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check_eq("reset out_valid", 32'(out_valid16), 32'd0);
        check_eq("reset in_ready", 32'(in_ready16), 32'd1);
        check_eq("reset sum", 32'(sum16), 32'd0);
        check_eq("reset cout", 32'(cout16), 32'd0);
        check_eq("reset ovf", 32'(ovf16), 32'd0);
        check_eq("reset dut8 out_valid", 32'(out_valid8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed arithmetic corners
        send16("add ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send16("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send16("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        send16("sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        send16("sub 9-3 borrow", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);

        // six back-to-back beats, out_ready dropped for 3 cycles at the first result
        begin
            logic [15:0] sa[6], sb[6];
            logic        ss[6], sc[6];
            int sent = 0, cyc = 0, hold_left = 0, start_pop;
            logic seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                sa[i] = 16'($urandom); sb[i] = 16'($urandom);
                ss[i] = 1'($urandom);  sc[i] = 1'($urandom);
            end
            stalls16 = 0;
            start_pop = n_pop16;
            while ((n_pop16 - start_pop) < 6 && cyc < 40) begin
                if (sent < 6) begin
                    in_valid16 = 1'b1;
                    a16 = sa[sent]; b16 = sb[sent]; sub16 = ss[sent]; cin16 = sc[sent];
                end else begin
                    in_valid16 = 1'b0;
                end
                if (!seen && out_valid16) begin
                    seen = 1'b1;
                    hold_left = 3;
                end
                out_ready16 = (hold_left == 0);
                if (hold_left > 0) hold_left--;
                tick16();
                if (acc16) sent++;
                cyc++;
            end
            in_valid16 = 1'b0;
            out_ready16 = 1'b1;
            check_eq("stream results", 32'(n_pop16 - start_pop), 32'd6);
            check_eq("stream stall cycles", 32'(stalls16), 32'd3);
            check_eq("stream leftovers", 32'(q16.size()), 32'd0);
        end

        // reset with beats in flight
        begin
            int seen_v = 0;
            out_ready16 = 1'b1;
            for (int i = 0; i < 4; i++) begin
                in_valid16 = 1'b1;
                a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'b0; cin16 = 1'b0;
                tick16();
            end
            in_valid16 = 1'b0;
            out_ready16 = 1'b0;
            #1;
            check_eq("pre-reset out_valid", 32'(out_valid16), 32'd1);
            #2 rst = 1'b1;
            #1;
            check_eq("mid-reset out_valid", 32'(out_valid16), 32'd0);
            check_eq("mid-reset in_ready", 32'(in_ready16), 32'd1);
            check_eq("mid-reset sum", 32'(sum16), 32'd0);
            q16.delete();
            q8.delete();
            hold16 = 1'b0;
            hold8 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            out_ready16 = 1'b1;
            repeat (8) begin
                tick16();
                seen_v += int'(out_valid16);
            end
            check_eq("post-reset idle out_valid", 32'(seen_v), 32'd0);
            send16("post-reset add", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        end

        // random regression, 16-bit then 8-bit
        begin
            int beats = 0, cyc = 0;
            while (beats < 10000 && cyc < 40000) begin
                in_valid16  = ($urandom_range(0, 3) != 0);
                out_ready16 = ($urandom_range(0, 3) != 0);
                a16 = 16'($urandom); b16 = 16'($urandom);
                sub16 = 1'($urandom); cin16 = 1'($urandom);
                tick16();
                if (acc16) beats++;
                cyc++;
            end
            in_valid16 = 1'b0;
            out_ready16 = 1'b1;
            cyc = 0;
            while (q16.size() != 0 && cyc < 20) begin
                tick16();
                cyc++;
            end
            check_eq("dut16 random beats", 32'(beats), 32'd10000);
            check_eq("dut16 random drained", 32'(q16.size()), 32'd0);
        end

        begin
            int beats = 0, cyc = 0, start_pop;
            start_pop = n_pop8;
            while (beats < 10000 && cyc < 40000) begin
                in_valid8  = ($urandom_range(0, 3) != 0);
                out_ready8 = ($urandom_range(0, 3) != 0);
                a8 = 8'($urandom); b8 = 8'($urandom);
                sub8 = 1'($urandom); cin8 = 1'($urandom);
                tick8();
                if (acc8) beats++;
                cyc++;
            end
            in_valid8 = 1'b0;
            out_ready8 = 1'b1;
            cyc = 0;
            while (q8.size() != 0 && cyc < 20) begin
                tick8();
                cyc++;
            end
            check_eq("dut8 random beats", 32'(beats), 32'd10000);
            check_eq("dut8 random results", 32'(n_pop8 - start_pop), 32'd10000);
            check_eq("dut8 random drained", 32'(q8.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
